// File: rtl/pixel_packet_sender.sv
// pixel_packet_sender: buffers camera pixels in a small FIFO and sends them as
// framed UART packets (8N1, LSB first): SYNC_BYTE, then PIXELS_PER_PKT pixels,
// each zero-extended to whole bytes and sent most-significant byte first.
// Optional build macro PIXEL_SENDER_CHECKSUM_EN appends one XOR checksum byte
// covering every pixel byte of the packet.
module pixel_packet_sender #(
  parameter int unsigned CLKS_PER_BIT   = 5208,
  parameter int unsigned PIXEL_W        = 12,
  parameter int unsigned PIXELS_PER_PKT = 4,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pixel_valid,
  input  logic [PIXEL_W-1:0] pixel,
  output logic               pixel_ready,
  output logic               uart_out,
  output logic               busy,
  output logic               pkt_done
);

  localparam int unsigned BPP = (PIXEL_W + 7) / 8;
  localparam int unsigned PW  = 8 * BPP;
`ifdef PIXEL_SENDER_CHECKSUM_EN
  localparam int unsigned NUM_BYTES = 2 + PIXELS_PER_PKT * BPP;
`else
  localparam int unsigned NUM_BYTES = 1 + PIXELS_PER_PKT * BPP;
`endif
  localparam int unsigned AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TW  = $clog2(CLKS_PER_BIT);
  localparam int unsigned BCW = $clog2(NUM_BYTES);
  localparam int unsigned BIW = (BPP > 1) ? $clog2(BPP) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_STOP} state_t;

  state_t             state_q;
  logic [PIXEL_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q, count_d;
  logic [PW-1:0]      pix_q;
  logic [7:0]         tx_byte_q;
  logic [TW-1:0]      clk_cnt_q;
  logic [2:0]         bit_idx_q;
  logic [BCW-1:0]     byte_cnt_q;
  logic [BIW-1:0]     bip_q;
  logic               uart_q, busy_q, pkt_done_q;

  logic               push, pop, is_sync, is_chk, bit_end;
  logic [PW-1:0]      head_ext, pix_src;
  logic [7:0]         pix_byte;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pixel_ready = (count_q != CW'(FIFO_DEPTH));
  assign push        = pixel_valid & pixel_ready;
  assign is_sync     = (byte_cnt_q == '0);
`ifdef PIXEL_SENDER_CHECKSUM_EN
  assign is_chk      = (byte_cnt_q == BCW'(NUM_BYTES - 1));
`else
  assign is_chk      = 1'b0;
`endif
  // A pixel leaves the FIFO when its first byte is selected in LOAD.
  assign pop         = (state_q == S_LOAD) && !is_sync && !is_chk && (bip_q == '0);
  assign head_ext    = PW'(mem_q[rd_ptr_q]);
  assign pix_src     = (bip_q == '0) ? head_ext : pix_q;
  assign pix_byte    = pix_src[PW-1 -: 8];
  assign bit_end     = (clk_cnt_q == TW'(CLKS_PER_BIT - 1));

  assign uart_out = uart_q;
  assign busy     = busy_q;
  assign pkt_done = pkt_done_q;

  // Next FIFO occupancy: simultaneous push and pop leave it unchanged.
  // NOTE: every output of an always_comb gets a default first so no latch is inferred.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage write port.
  // NOTE: the storage array is deliberately not reset; count and pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= pixel;
  end

  // FIFO pointers and occupancy; reset empties the FIFO.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_d;
    end
  end

`ifdef PIXEL_SENDER_CHECKSUM_EN
  logic [7:0] chk_q;

  // Checksum accumulator: XOR of the pixel bytes, cleared between packets.
  always_ff @(posedge clk) begin
    if (!rst) begin
      chk_q <= '0;
    end else if (state_q == S_IDLE) begin
      chk_q <= '0;
    end else if (state_q == S_LOAD && !is_sync && !is_chk) begin
      chk_q <= chk_q ^ pix_byte;
    end
  end
`endif

  // Packet sequencer and UART transmitter with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      uart_q     <= 1'b1;
      busy_q     <= 1'b0;
      pkt_done_q <= 1'b0;
      pix_q      <= '0;
      tx_byte_q  <= '0;
      clk_cnt_q  <= '0;
      bit_idx_q  <= '0;
      byte_cnt_q <= '0;
      bip_q      <= '0;
    end else begin
      pkt_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          uart_q     <= 1'b1;
          byte_cnt_q <= '0;
          bip_q      <= '0;
          if (count_q >= CW'(PIXELS_PER_PKT)) begin
            state_q <= S_LOAD;
            busy_q  <= 1'b1;
          end
        end
        S_LOAD: begin
          uart_q    <= 1'b0;
          clk_cnt_q <= '0;
          bit_idx_q <= '0;
          state_q   <= S_START;
          if (is_sync) begin
            tx_byte_q <= SYNC_BYTE;
`ifdef PIXEL_SENDER_CHECKSUM_EN
          end else if (is_chk) begin
            tx_byte_q <= chk_q;
`endif
          end else begin
            tx_byte_q <= pix_byte;
            pix_q     <= pix_src << 8;
            bip_q     <= (bip_q == BIW'(BPP - 1)) ? '0 : bip_q + 1'b1;
          end
        end
        S_START: begin
          if (bit_end) begin
            clk_cnt_q <= '0;
            uart_q    <= tx_byte_q[0];
            state_q   <= S_DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            clk_cnt_q <= '0;
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              uart_q  <= 1'b1;
              state_q <= S_STOP;
            end else begin
              uart_q  <= tx_byte_q[bit_idx_q + 3'd1];
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            clk_cnt_q <= '0;
            if (byte_cnt_q == BCW'(NUM_BYTES - 1)) begin
              state_q    <= S_IDLE;
              busy_q     <= 1'b0;
              pkt_done_q <= 1'b1;
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
              state_q    <= S_LOAD;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_packet_sender.sv
// Self-checking bench for pixel_packet_sender (CLKS_PER_BIT=4, 12-bit pixels,
// 4 pixels per packet, 8-entry FIFO). The UART line is decoded back to bytes
// and compared with table vectors and with a queue-based packet model.
module tb_pixel_packet_sender;

  localparam int CPB   = 4;
  localparam int PW    = 12;
  localparam int PPP   = 4;
  localparam int DEPTH = 8;
  localparam int BPP   = (PW + 7) / 8;
`ifdef PIXEL_SENDER_CHECKSUM_EN
  localparam int NB = 2 + PPP * BPP;
`else
  localparam int NB = 1 + PPP * BPP;
`endif
  localparam int BYTE_T = 10 * CPB + 1;
  localparam int PKT_T  = NB * BYTE_T + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          pixel_valid = 1'b0;
  logic [PW-1:0] pixel = '0;
  logic          pixel_ready, uart_out, busy, pkt_done;

  pixel_packet_sender #(
    .CLKS_PER_BIT(CPB), .PIXEL_W(PW), .PIXELS_PER_PKT(PPP),
    .FIFO_DEPTH(DEPTH), .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk), .rst(rst), .pixel_valid(pixel_valid), .pixel(pixel),
    .pixel_ready(pixel_ready), .uart_out(uart_out), .busy(busy), .pkt_done(pkt_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic [7:0]    rx_q[$];
  logic [7:0]    exp_q[$];
  logic [PW-1:0] model_q[$];
  int            start_q[$];
  int            done_q[$];
  int            frame_err = 0;
  int            dbl_pulse = 0;

  typedef struct {
    logic [PW-1:0] px    [PPP];
    logic [7:0]    bytes [1 + PPP * BPP];
    logic [7:0]    chk;
  } vec_t;
  vec_t tbl [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line monitor: decodes 8N1 frames mid-bit and records byte start and pkt_done cycles.
  initial begin
    bit         act;
    int         t;
    logic [7:0] b;
    logic       prev_done;
    act = 1'b0; t = 0; b = '0; prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (pkt_done) begin
        done_q.push_back(cyc);
        if (prev_done) dbl_pulse++;
      end
      prev_done = pkt_done;
      if (!rst) begin
        act = 1'b0;
      end else if (!act) begin
        if (uart_out == 1'b0) begin
          act = 1'b1;
          t = 0;
          start_q.push_back(cyc);
        end
      end else begin
        t++;
        if (t >= CPB + CPB / 2 && t < 9 * CPB && ((t - CPB / 2) % CPB) == 0)
          b[(t - CPB / 2) / CPB - 1] = uart_out;
        if (t == 9 * CPB + CPB / 2) begin
          if (uart_out !== 1'b1) frame_err++;
          rx_q.push_back(b);
          act = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_queues();
    rx_q.delete(); exp_q.delete(); model_q.delete();
    start_q.delete(); done_q.delete();
    frame_err = 0; dbl_pulse = 0;
  endtask

  task automatic do_reset();
    pixel_valid = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    clear_queues();
    rst = 1'b1;
  endtask

  task automatic push_px(input logic [PW-1:0] v, output int at);
    pixel_valid = 1'b1;
    pixel = v;
    @(negedge clk);
    at = cyc;
    pixel_valid = 1'b0;
  endtask

  task automatic wait_pkts(input int n);
    int t = 0;
    while (done_q.size() < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("pkt_count_wait", done_q.size(), n);
  endtask

  // Reference packetiser: every PPP accepted pixels form one packet.
  function automatic void model_flush();
    logic [7:0]  c;
    logic [31:0] v;
    while (model_q.size() >= PPP) begin
      exp_q.push_back(8'hA5);
      c = '0;
      for (int p = 0; p < PPP; p++) begin
        v = 32'(model_q.pop_front());
        for (int k = BPP - 1; k >= 0; k--) begin
          exp_q.push_back(v[8 * k +: 8]);
          c ^= v[8 * k +: 8];
        end
      end
`ifdef PIXEL_SENDER_CHECKSUM_EN
      exp_q.push_back(c);
`endif
    end
  endfunction

  task automatic compare_stream(input string name);
    check({name, "_len"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check($sformatf("%s_byte%0d", name, i), rx_q[i], exp_q[i]);
  endtask

  task automatic load_vec_expect(input int i);
    exp_q.delete();
    for (int k = 0; k < 1 + PPP * BPP; k++) exp_q.push_back(tbl[i].bytes[k]);
`ifdef PIXEL_SENDER_CHECKSUM_EN
    exp_q.push_back(tbl[i].chk);
`endif
  endtask

  initial begin
    int last, carry, total, n;
    logic [PW-1:0] v;

    tbl[0].px    = '{12'h123, 12'h456, 12'h789, 12'hABC};
    tbl[0].bytes = '{8'hA5, 8'h01, 8'h23, 8'h04, 8'h56, 8'h07, 8'h89, 8'h0A, 8'hBC};
    tbl[0].chk   = 8'h48;
    tbl[1].px    = '{12'hF00, 12'hFFF, 12'h001, 12'h800};
    tbl[1].bytes = '{8'hA5, 8'h0F, 8'h00, 8'h0F, 8'hFF, 8'h00, 8'h01, 8'h08, 8'h00};
    tbl[1].chk   = 8'hF6;
    tbl[2].px    = '{12'h0F0, 12'h00F, 12'h000, 12'h000};
    tbl[2].bytes = '{8'hA5, 8'h00, 8'hF0, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[2].chk   = 8'hFF;

    // Reset state.
    do_reset();
    check("rst_uart", uart_out, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", pkt_done, 1'b0);
    check("rst_ready", pixel_ready, 1'b1);

    // Table-driven single packets with framing and timing checks.
    for (int i = 0; i < 3; i++) begin
      do_reset();
      last = 0;
      for (int p = 0; p < PPP; p++) push_px(tbl[i].px[p], last);
      check("busy_before_start", busy, 1'b0);
      @(negedge clk);
      check("busy_rise", busy, 1'b1);
      wait_pkts(1);
      repeat (20) @(negedge clk);
      load_vec_expect(i);
      compare_stream($sformatf("vec%0d", i));
      check("byte_starts", start_q.size(), NB);
      if (start_q.size() >= 1) check("first_start_latency", start_q[0] - last, 2);
      for (int k = 1; k < start_q.size(); k++)
        check("byte_spacing", start_q[k] - start_q[k - 1], BYTE_T);
      if (start_q.size() >= 1 && done_q.size() >= 1)
        check("done_after_stop", done_q[0] - start_q[start_q.size() - 1], 10 * CPB);
      check("busy_after", busy, 1'b0);
      check("ready_after", pixel_ready, 1'b1);
      check("done_single_cycle", dbl_pulse, 0);
      check("framing", frame_err, 0);
    end

    // FIFO fill to full with no pop, 9th pixel dropped, then two back-to-back packets.
    do_reset();
    pixel_valid = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      v = PW'($urandom);
      pixel = v;
      check($sformatf("ready_fill%0d", i), pixel_ready, (model_q.size() < DEPTH));
      if (model_q.size() < DEPTH) model_q.push_back(v);
      @(negedge clk);
    end
    pixel_valid = 1'b0;
    model_flush();
    wait_pkts(2);
    repeat (PKT_T) @(negedge clk);
    check("full_pkt_count", done_q.size(), 2);
    if (done_q.size() >= 2) check("b2b_period", done_q[1] - done_q[0], PKT_T);
    compare_stream("full");
    check("full_busy_after", busy, 1'b0);
    check("full_ready_after", pixel_ready, 1'b1);
    check("full_done_single_cycle", dbl_pulse, 0);

    // Reset in the middle of the second byte's data bits.
    do_reset();
    for (int p = 0; p < PPP; p++) push_px(tbl[1].px[p], last);
    n = 0;
    while (start_q.size() < 2 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("abort_second_byte_seen", start_q.size(), 2);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_uart", uart_out, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_done", pkt_done, 1'b0);
    check("abort_ready", pixel_ready, 1'b1);
    rst = 1'b1;
    repeat (PKT_T) @(negedge clk);
    check("abort_no_done", done_q.size(), 0);
    check("abort_idle_line", uart_out, 1'b1);
    check("abort_idle_busy", busy, 1'b0);
    rx_q.delete(); start_q.delete();
    for (int p = 0; p < PPP; p++) push_px(tbl[2].px[p], last);
    wait_pkts(1);
    repeat (20) @(negedge clk);
    load_vec_expect(2);
    compare_stream("after_abort");

    // Randomized traffic with random gaps, checked against the packet model.
    do_reset();
    carry = 0;
    total = 0;
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, DEPTH - carry);
      for (int j = 0; j < n; j++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        v = PW'($urandom);
        check("ready_rand", pixel_ready, 1'b1);
        push_px(v, last);
        model_q.push_back(v);
      end
      carry += n;
      total += carry / PPP;
      carry = carry % PPP;
      wait_pkts(total);
    end
    repeat (50) @(negedge clk);
    model_flush();
    compare_stream("rand");
    check("rand_done_single_cycle", dbl_pulse, 0);
    check("rand_framing", frame_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
